// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token, a hold-time limit
// and a one-cycle turnaround gap between grants.
module ring_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic [2:0]   owner,
  output logic         timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  state_t        state_r;
  logic [N-1:0]  ptr_r;
  logic [HW-1:0] hold_cnt_r;

  logic [2:0]    ptr_idx_s;
  logic [3:0]    cand_s;
  logic          found_s;
  logic [2:0]    win_idx_s;
  logic          hold_max_s;
  logic          release_s;
  logic [2:0]    next_ptr_idx_s;

  // Binary position of the priority token.
  always_comb begin
    ptr_idx_s = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (ptr_r[i]) begin
        ptr_idx_s = 3'(i);
      end else begin
        ptr_idx_s = ptr_idx_s;
      end
    end
  end

  // Scan requesters starting at the token, wrapping past N-1.
  always_comb begin
    found_s   = 1'b0;
    win_idx_s = 3'd0;
    cand_s    = 4'd0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_idx_s} + 4'(i);
      if (cand_s >= 4'(N)) begin
        cand_s = cand_s - 4'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[2:0]]) begin
        found_s   = 1'b1;
        win_idx_s = cand_s[2:0];
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Release conditions for the current owner and the token position after it.
  always_comb begin
    hold_max_s     = (hold_cnt_r == HW'(MAX_HOLD));
    release_s      = done[owner] || !req[owner] || hold_max_s;
    if (owner == 3'(N - 1)) begin
      next_ptr_idx_s = 3'd0;
    end else begin
      next_ptr_idx_s = owner + 3'd1;
    end
  end

  // Arbitration state machine with registered outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r    <= IDLE;
      ptr_r      <= ONE_HOT0;
      hold_cnt_r <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      owner      <= 3'd0;
      timeout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, GAP: begin
          timeout <= 1'b0;
          if (found_s) begin
            state_r    <= GRANT;
            gnt        <= ONE_HOT0 << win_idx_s;
            busy       <= 1'b1;
            owner      <= win_idx_s;
            hold_cnt_r <= HW'(1);
          end else begin
            state_r    <= IDLE;
            gnt        <= '0;
            busy       <= 1'b0;
            owner      <= 3'd0;
            hold_cnt_r <= '0;
          end
        end
        GRANT: begin
          if (release_s) begin
            state_r    <= GAP;
            gnt        <= '0;
            busy       <= 1'b0;
            owner      <= 3'd0;
            hold_cnt_r <= '0;
            ptr_r      <= ONE_HOT0 << next_ptr_idx_s;
            // Only a pure hold-limit release is reported as a timeout.
            timeout    <= hold_max_s && !done[owner] && req[owner];
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
            timeout    <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          ptr_r      <= ONE_HOT0;
          hold_cnt_r <= '0;
          gnt        <= '0;
          busy       <= 1'b0;
          owner      <= 3'd0;
          timeout    <= 1'b0;
        end
      endcase
    end
  end

endmodule
